// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder
//   Takes symbolic RV32I instruction requests over a valid/ready handshake and
//   assembles them into 32-bit machine words. The words are written one after
//   another into instruction memory, starting at word 0 of a load session.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   start, finish           open a session at address 0 / close the session
//   req_valid, req_ready    request handshake (ready only while loading)
//   req_op                  op enum 0..36 (ADD..JALR)
//   req_rd/rs1/rs2          register indices
//   req_imm                 signed immediate value (full value for LUI/AUIPC)
//   im_we/im_addr/im_wdata  instruction memory write port, one cycle after accept
//   word_count              words written in this session
//   busy, full, done, err   session open, memory full, close pulse, sticky reject
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no session; start opens one at address 0
// LOAD  | accepting requests, one memory write per accepted request
// FULL  | DEPTH words written; requests stall until finish
module rv32i_instr_encoder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] WC_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] WC_MAX  = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;

    logic [2:0]          f3;
    logic [31:0]         enc_word;
    logic                imm_ok;
    logic                fits12, fits13, fits21;

    // Sign-extension checks: upper bits must all equal the sign bit.
    assign fits12 = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    assign fits13 = (&req_imm[31:12]) | ~(|req_imm[31:12]);
    assign fits21 = (&req_imm[31:20]) | ~(|req_imm[31:20]);

    always_comb begin
        f3 = 3'b000;
        case (req_op)
            6'd2,  6'd16, 6'd20, 6'd25, 6'd28:        f3 = 3'b001;
            6'd3,  6'd11, 6'd21, 6'd26:               f3 = 3'b010;
            6'd4,  6'd12:                             f3 = 3'b011;
            6'd5,  6'd13, 6'd22, 6'd29:               f3 = 3'b100;
            6'd6,  6'd7,  6'd17, 6'd18, 6'd23, 6'd30: f3 = 3'b101;
            6'd8,  6'd14, 6'd31:                      f3 = 3'b110;
            6'd9,  6'd15, 6'd32:                      f3 = 3'b111;
            default:                                  f3 = 3'b000;
        endcase
    end

    always_comb begin
        enc_word = '0;
        imm_ok   = 1'b0;
        if (req_op <= 6'd9) begin
            // SUB (1) and SRA (7) carry funct7 = 0100000
            imm_ok   = 1'b1;
            enc_word = {((req_op == 6'd1) || (req_op == 6'd7)) ? 7'b0100000 : 7'b0000000,
                        req_rs2, req_rs1, f3, req_rd, 7'b0110011};
        end else if (req_op <= 6'd15) begin
            imm_ok   = fits12;
            enc_word = {req_imm[11:0], req_rs1, f3, req_rd, 7'b0010011};
        end else if (req_op <= 6'd18) begin
            imm_ok   = ~(|req_imm[31:5]);
            enc_word = {(req_op == 6'd18) ? 7'b0100000 : 7'b0000000,
                        req_imm[4:0], req_rs1, f3, req_rd, 7'b0010011};
        end else if (req_op <= 6'd23) begin
            imm_ok   = fits12;
            enc_word = {req_imm[11:0], req_rs1, f3, req_rd, 7'b0000011};
        end else if (req_op <= 6'd26) begin
            imm_ok   = fits12;
            enc_word = {req_imm[11:5], req_rs2, req_rs1, f3, req_imm[4:0], 7'b0100011};
        end else if (req_op <= 6'd32) begin
            imm_ok   = fits13 & ~req_imm[0];
            enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, f3,
                        req_imm[4:1], req_imm[11], 7'b1100011};
        end else if (req_op == 6'd33) begin
            imm_ok   = ~(|req_imm[11:0]);
            enc_word = {req_imm[31:12], req_rd, 7'b0110111};
        end else if (req_op == 6'd34) begin
            imm_ok   = ~(|req_imm[11:0]);
            enc_word = {req_imm[31:12], req_rd, 7'b0010111};
        end else if (req_op == 6'd35) begin
            imm_ok   = fits21 & ~req_imm[0];
            enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                        req_rd, 7'b1101111};
        end else if (req_op == 6'd36) begin
            imm_ok   = fits12;
            enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b1100111};
        end
    end

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    wc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (req_valid) begin
                    if (imm_ok) begin
                        we_d    = 1'b1;
                        addr_d  = wc_q[ADDR_W-1:0];
                        wdata_d = enc_word;
                        wc_d    = wc_q + 1'b1;
                        if (wc_q == WC_LAST) begin
                            state_d = S_FULL;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // finish wins over the FULL transition; a word accepted on
                // the same edge is still written.
                if (finish) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_FULL: begin
                if (finish) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wc_q    <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign req_ready  = (state_q == S_LOAD);
    assign busy       = (state_q != S_IDLE);
    assign full       = (wc_q == WC_MAX);
    assign word_count = wc_q;
    assign err        = err_q;
    assign done       = done_q;
    assign im_we      = we_q;
    assign im_addr    = addr_q;
    assign im_wdata   = wdata_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
module tb_rv32i_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, finish, req_valid, sel4;
    logic [5:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;

    // instance A: DEPTH 256
    logic        a_ready, a_we, a_busy, a_full, a_done, a_err;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [8:0]  a_wc;
    // instance B: DEPTH 4
    logic        b_ready, b_we, b_busy, b_full, b_done, b_err;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_wc;

    logic a_start, a_finish, a_valid, b_start, b_finish, b_valid;
    assign a_start  = start & ~sel4;
    assign a_finish = finish & ~sel4;
    assign a_valid  = req_valid & ~sel4;
    assign b_start  = start & sel4;
    assign b_finish = finish & sel4;
    assign b_valid  = req_valid & sel4;

    logic rdy, dn, bsy;
    assign rdy = sel4 ? b_ready : a_ready;
    assign dn  = sel4 ? b_done  : a_done;
    assign bsy = sel4 ? b_busy  : a_busy;

    rv32i_instr_encoder #(.DEPTH(256)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(a_start), .finish(a_finish),
        .req_valid(a_valid), .req_ready(a_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .im_we(a_we), .im_addr(a_addr), .im_wdata(a_wdata), .word_count(a_wc),
        .busy(a_busy), .full(a_full), .done(a_done), .err(a_err)
    );

    rv32i_instr_encoder #(.DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .finish(b_finish),
        .req_valid(b_valid), .req_ready(b_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .im_we(b_we), .im_addr(b_addr), .im_wdata(b_wdata), .word_count(b_wc),
        .busy(b_busy), .full(b_full), .done(b_done), .err(b_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // funct3 by op number
    bit [2:0] F3 [37] = '{3'd0,3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd5,3'd6,3'd7,
                          3'd0,3'd2,3'd3,3'd4,3'd6,3'd7,3'd1,3'd5,3'd5,
                          3'd0,3'd1,3'd2,3'd4,3'd5,
                          3'd0,3'd1,3'd2,
                          3'd0,3'd1,3'd4,3'd5,3'd6,3'd7,
                          3'd0,3'd0,3'd0,3'd0};

    // Reference model: {accepted, word} from the RV32I format rules.
    function automatic logic [32:0] model(input bit [31:0] op, input bit [31:0] rd,
                                          input bit [31:0] rs1, input bit [31:0] rs2,
                                          input int imm);
        bit [31:0] u;
        bit [31:0] w;
        bit [31:0] f;
        bit        ok;
        u  = imm;
        w  = 32'd0;
        ok = 1'b0;
        if (op > 32'd36) return 33'd0;
        f = 32'(F3[op]) << 12;
        if (op <= 9) begin
            ok = 1'b1;
            w  = 32'h33 | (rd << 7) | f | (rs1 << 15) | (rs2 << 20)
               | ((op == 1 || op == 7) ? (32'h20 << 25) : 32'd0);
        end else if (op <= 15 || (op >= 19 && op <= 23)) begin
            ok = (imm >= -2048) && (imm <= 2047);
            w  = ((op <= 15) ? 32'h13 : 32'h03) | (rd << 7) | f | (rs1 << 15)
               | ((u & 32'hFFF) << 20);
        end else if (op <= 18) begin
            ok = (imm >= 0) && (imm <= 31);
            w  = 32'h13 | (rd << 7) | f | (rs1 << 15) | ((u & 32'd31) << 20)
               | ((op == 18) ? (32'd1 << 30) : 32'd0);
        end else if (op <= 26) begin
            ok = (imm >= -2048) && (imm <= 2047);
            w  = 32'h23 | ((u & 32'd31) << 7) | f | (rs1 << 15) | (rs2 << 20)
               | (((u >> 5) & 32'd127) << 25);
        end else if (op <= 32) begin
            ok = (imm >= -4096) && (imm <= 4095) && (imm % 2 == 0);
            w  = 32'h63 | (((u >> 11) & 32'd1) << 7) | (((u >> 1) & 32'd15) << 8) | f
               | (rs1 << 15) | (rs2 << 20) | (((u >> 5) & 32'd63) << 25)
               | (((u >> 12) & 32'd1) << 31);
        end else if (op <= 34) begin
            ok = (u & 32'hFFF) == 32'd0;
            w  = ((op == 33) ? 32'h37 : 32'h17) | (rd << 7) | (u & 32'hFFFFF000);
        end else if (op == 35) begin
            ok = (imm >= -(1 << 20)) && (imm < (1 << 20)) && (imm % 2 == 0);
            w  = 32'h6F | (rd << 7) | (((u >> 12) & 32'd255) << 12)
               | (((u >> 11) & 32'd1) << 20) | (((u >> 1) & 32'd1023) << 21)
               | (((u >> 20) & 32'd1) << 31);
        end else begin
            ok = (imm >= -2048) && (imm <= 2047);
            w  = 32'h67 | (rd << 7) | (rs1 << 15) | ((u & 32'hFFF) << 20);
        end
        return {ok, w};
    endfunction

    logic [39:0] qa[$];
    logic [39:0] qb[$];
    int exp_wc;
    bit exp_err;

    always @(negedge clk) begin
        logic [39:0] e;
        if (rst_n && a_we) begin
            if (qa.size() == 0) chk("a_unexpected_we", 64'(a_we), 64'd0);
            else begin
                e = qa.pop_front();
                chk("a_addr", 64'(a_addr), 64'(e[39:32]));
                chk("a_wdata", 64'(a_wdata), 64'(e[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [39:0] e;
        if (rst_n && b_we) begin
            if (qb.size() == 0) chk("b_unexpected_we", 64'(b_we), 64'd0);
            else begin
                e = qb.pop_front();
                chk("b_addr", 64'(b_addr), 64'(e[39:32]));
                chk("b_wdata", 64'(b_wdata), 64'(e[31:0]));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit [31:0] op, input bit [31:0] rd, input bit [31:0] rs1,
                        input bit [31:0] rs2, input int imm, input bit fin);
        logic [32:0] m;
        bit [31:0]   iu;
        int          n;
        iu        = imm;
        req_op    = op[5:0];
        req_rd    = rd[4:0];
        req_rs1   = rs1[4:0];
        req_rs2   = rs2[4:0];
        req_imm   = iu;
        req_valid = 1'b1;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            chk("ready_timeout", 64'(rdy), 64'd1);
            req_valid = 1'b0;
            return;
        end
        finish = fin;
        m = model(op, rd, rs1, rs2, imm);
        if (m[32]) begin
            if (sel4) qb.push_back({exp_wc[7:0], m[31:0]});
            else      qa.push_back({exp_wc[7:0], m[31:0]});
            exp_wc++;
        end else begin
            exp_err = 1'b1;
        end
        @(negedge clk);
        finish = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic open_session();
        req_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_wc  = 0;
        exp_err = 1'b0;
    endtask

    task automatic close_session();
        req_valid = 1'b0;
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        chk("done_pulse", 64'(dn), 64'd1);
        @(negedge clk);
        chk("done_low", 64'(dn), 64'd0);
        chk("busy_after_finish", 64'(bsy), 64'd0);
    endtask

    function automatic int rand_imm();
        case ($urandom_range(0, 4))
            0:       return int'($urandom_range(0, 4095)) - 2048;
            1:       return int'($urandom_range(0, 40));
            2:       return int'($urandom & 32'hFFFFF000);
            3:       return int'($urandom_range(0, 8191)) - 4096;
            default: return int'($urandom_range(0, 32'h1FFFFF)) - 32'sh100000;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; req_valid = 1'b0; sel4 = 1'b0;
        req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        exp_wc = 0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(a_ready), 64'd0);
        chk("rst_we", 64'(a_we), 64'd0);
        chk("rst_wc", 64'(a_wc), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_full", 64'(a_full), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_err", 64'(a_err), 64'd0);
        chk("rst_addr", 64'(a_addr), 64'd0);
        chk("rst_wdata", 64'(a_wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed formats
        open_session();
        chk("busy_open", 64'(a_busy), 64'd1);
        chk("ready_open", 64'(a_ready), 64'd1);
        send(0, 3, 1, 2, 0, 0);
        chk("add_word", 64'(a_wdata), 64'h002081B3);
        chk("add_addr", 64'(a_addr), 64'd0);
        send(1, 5, 6, 7, 0, 0);
        chk("sub_word", 64'(a_wdata), 64'h407302B3);
        chk("sub_addr", 64'(a_addr), 64'd1);
        send(10, 1, 0, 0, -1, 0);
        chk("addi_word", 64'(a_wdata), 64'hFFF00093);
        send(26, 0, 1, 2, 8, 0);
        chk("sw_word", 64'(a_wdata), 64'h0020A423);
        send(27, 0, 0, 0, -4, 0);
        chk("beq_word", 64'(a_wdata), 64'hFE000EE3);
        send(35, 1, 0, 0, 8, 0);
        chk("jal_word", 64'(a_wdata), 64'h008000EF);
        idle(1);

        // rejected requests
        send(10, 1, 0, 0, 2048, 0);
        chk("rej_addi_we", 64'(a_we), 64'd0);
        chk("rej_addi_err", 64'(a_err), 64'd1);
        chk("rej_addi_wc", 64'(a_wc), 64'd6);
        send(27, 0, 0, 0, 3, 0);
        chk("rej_beq_we", 64'(a_we), 64'd0);
        chk("rej_beq_wc", 64'(a_wc), 64'd6);
        send(63, 1, 2, 3, 0, 0);
        chk("rej_op_we", 64'(a_we), 64'd0);
        chk("rej_op_err", 64'(a_err), 64'd1);
        chk("rej_op_wc", 64'(a_wc), 64'd6);
        close_session();

        // randomized session
        open_session();
        chk("err_cleared", 64'(a_err), 64'd0);
        chk("wc_cleared", 64'(a_wc), 64'd0);
        for (int i = 0; i < 150; i++) begin
            send($urandom_range(0, 40), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), rand_imm(), 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
        chk("rand_wc", 64'(a_wc), 64'(exp_wc));
        chk("rand_err", 64'(a_err), 64'(exp_err));
        close_session();

        // streaming, finish with the last word
        open_session();
        for (int i = 0; i < 8; i++) begin
            send(10, i + 1, i, 0, i * 3 - 7, i == 7);
            chk("stream_we", 64'(a_we), 64'd1);
            chk("stream_addr", 64'(a_addr), 64'(i));
        end
        chk("stream_done", 64'(a_done), 64'd1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("stream_done_low", 64'(a_done), 64'd0);
        chk("stream_idle", 64'(a_busy), 64'd0);

        // full on the DEPTH=4 instance
        sel4 = 1'b1;
        open_session();
        chk("b_wc_open", 64'(b_wc), 64'd0);
        for (int i = 0; i < 4; i++) send(0, i + 1, i + 2, i + 3, 0, 0);
        chk("b_full", 64'(b_full), 64'd1);
        chk("b_ready_full", 64'(b_ready), 64'd0);
        chk("b_wc_full", 64'(b_wc), 64'd4);
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("b_stall_ready", 64'(b_ready), 64'd0);
        chk("b_stall_wc", 64'(b_wc), 64'd4);
        chk("b_stall_busy", 64'(b_busy), 64'd1);
        close_session();
        sel4 = 1'b0;

        // reset mid-session
        open_session();
        for (int i = 0; i < 3; i++) send(8, i, i, i, 0, 0);
        chk("pre_reset_we", 64'(a_we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_we", 64'(a_we), 64'd0);
        chk("reset_wc", 64'(a_wc), 64'd0);
        chk("reset_busy", 64'(a_busy), 64'd0);
        chk("reset_ready", 64'(a_ready), 64'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
